floor_request_scheduler: RTL and testbench

FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

---
 rtl/elevator_pkg.sv | 10 +
 rtl/floor_priority_enc.sv | 31 +++
 rtl/floor_request_scheduler.sv | 93 +++++++++
 tb/tb_floor_request_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor-count defaults and the scan-direction encoding
package elevator_pkg;
  localparam int NUM_FLOORS_DFLT = 6;
  localparam int FLOOR_W_DFLT    = 3;
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;
endpackage

// File: rtl/floor_priority_enc.sv
// floor_priority_enc: nearest requested floor strictly above and strictly below the current floor
module floor_priority_enc
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DFLT,
  parameter int FLOOR_W    = FLOOR_W_DFLT
) (
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    above,
  output logic [FLOOR_W-1:0]    below,
  output logic                  found_above,
  output logic                  found_below
);
  always_comb begin
    above = '0;
    below = '0;
    found_above = 1'b0;
    found_below = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (req[i] && FLOOR_W'(i) > cur_floor) begin
        above = FLOOR_W'(i);
        found_above = 1'b1;
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (req[i] && FLOOR_W'(i) < cur_floor) begin
        below = FLOOR_W'(i);
        found_below = 1'b1;
      end
  end
endmodule

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: latches car/hall calls and runs an up/down scan to pick the next stop
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DFLT,
  parameter int FLOOR_W    = FLOOR_W_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  service,
  input  logic [NUM_FLOORS-1:0] btn_num_in,
  input  logic [NUM_FLOORS-1:0] btn_up_out,
  input  logic [NUM_FLOORS-1:0] btn_down_out,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  serve,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic [1:0]            dir,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DOWN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  logic [NUM_FLOORS-1:0] car_q, car_d, up_q, up_d, down_q, down_d;
  logic [NUM_FLOORS-1:0] cf_oh, clr_car, clr_up, clr_down, here_mask;
  logic [FLOOR_W-1:0]    above, below, target_floor_q, target_floor_d;
  logic                  found_above, found_below, cf_ok, ahead, here, go_down;
  logic                  target_valid_q, target_valid_d;
  dir_e                  state_q, state_d;

  floor_priority_enc #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_enc (
    .req(pending), .cur_floor(current_floor), .above(above), .below(below),
    .found_above(found_above), .found_below(found_below)
  );

  assign pending      = car_q | up_q | down_q;
  assign cf_ok        = {1'b0, current_floor} < (FLOOR_W+1)'(NUM_FLOORS);
  assign cf_oh        = cf_ok ? NUM_FLOORS'(1) << current_floor : '0;
  assign ahead        = (state_q == DIR_UP && found_above) || (state_q == DIR_DOWN && found_below);
  assign clr_car      = serve ? cf_oh : '0;
  assign clr_up       = (serve && (state_q != DIR_DOWN || !ahead)) ? cf_oh : '0;
  assign clr_down     = (serve && (state_q != DIR_UP || !ahead)) ? cf_oh : '0;
  assign car_d        = service ? '0 : (car_q & ~clr_car) | btn_num_in;
  assign up_d         = service ? '0 : (up_q & ~clr_up) | (btn_up_out & UP_MASK);
  assign down_d       = service ? '0 : (down_q & ~clr_down) | (btn_down_out & DOWN_MASK);
  assign here_mask    = state_q == DIR_UP ? car_q | up_q : state_q == DIR_DOWN ? car_q | down_q : pending;
  assign here         = |(cf_oh & here_mask);
  // below wins over above only while already heading down or when nothing is above
  assign go_down      = found_below && (state_q == DIR_DOWN || !found_above);
  assign target_floor = target_floor_q;
  assign target_valid = target_valid_q;
  assign dir          = state_q;

  always_comb begin
    state_d = state_q;
    target_floor_d = target_floor_q;
    target_valid_d = 1'b0;
    if (service) begin
      state_d = DIR_IDLE;
      target_floor_d = '0;
    end else if (cf_ok) begin
      if (here) begin
        target_floor_d = current_floor;
        target_valid_d = 1'b1;
      end else if (found_above && !go_down) begin
        state_d = DIR_UP;
        target_floor_d = above;
        target_valid_d = 1'b1;
      end else if (go_down) begin
        state_d = DIR_DOWN;
        target_floor_d = below;
        target_valid_d = 1'b1;
      end else state_d = DIR_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      car_q <= '0;
      up_q <= '0;
      down_q <= '0;
      state_q <= DIR_IDLE;
      target_floor_q <= '0;
      target_valid_q <= 1'b0;
    end else begin
      car_q <= car_d;
      up_q <= up_d;
      down_q <= down_d;
      state_q <= state_d;
      target_floor_q <= target_floor_d;
      target_valid_q <= target_valid_d;
    end
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: directed scenarios plus random traffic against a per-floor call model
module tb_floor_request_scheduler;
  localparam int NF = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          service = 1'b0;
  logic [NF-1:0] btn_num_in = '0, btn_up_out = '0, btn_down_out = '0;
  logic [2:0]    current_floor = '0;
  logic          serve = 1'b0;
  logic [2:0]    target_floor;
  logic          target_valid;
  logic [1:0]    dir;
  logic [NF-1:0] pending;

  int total = 0, bad = 0;
  bit [7:0] m_car, m_up, m_down;
  int m_st, m_tgt;
  bit m_vld;

  floor_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(3)) dut (
    .clk(clk), .reset(reset), .service(service), .btn_num_in(btn_num_in),
    .btn_up_out(btn_up_out), .btn_down_out(btn_down_out), .current_floor(current_floor),
    .serve(serve), .target_floor(target_floor), .target_valid(target_valid),
    .dir(dir), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_car = 0; m_up = 0; m_down = 0;
    m_st = 0; m_tgt = 0; m_vld = 0;
  endtask

  // floor-by-floor reading of the scan rules; FSM sees the calls latched before this edge
  task automatic model_step();
    int cf, na, nb, st;
    bit [7:0] p;
    bit ahead;
    cf = int'(current_floor);
    na = -1;
    nb = -1;
    st = m_st;
    p = m_car | m_up | m_down;
    for (int f = NF - 1; f >= 0; f--) if (p[f] && f > cf) na = f;
    for (int f = 0; f < NF; f++) if (p[f] && f < cf) nb = f;
    if (service) begin m_st = 0; m_tgt = 0; m_vld = 0; end
    else if (cf >= NF) m_vld = 0;
    else if (st == 0 && p[cf]) begin m_tgt = cf; m_vld = 1; end
    else if (st == 1 && (m_car[cf] || m_up[cf])) begin m_tgt = cf; m_vld = 1; end
    else if (st == 2 && (m_car[cf] || m_down[cf])) begin m_tgt = cf; m_vld = 1; end
    else if (na >= 0 && (st != 2 || nb < 0)) begin m_st = 1; m_tgt = na; m_vld = 1; end
    else if (nb >= 0) begin m_st = 2; m_tgt = nb; m_vld = 1; end
    else begin m_st = 0; m_vld = 0; end
    if (service) begin
      m_car = 0; m_up = 0; m_down = 0;
    end else begin
      if (serve && cf < NF) begin
        ahead = (st == 1 && na >= 0) || (st == 2 && nb >= 0);
        m_car[cf] = 0;
        if (st == 1 || !ahead) m_up[cf] = 0;
        if (st == 2 || !ahead) m_down[cf] = 0;
      end
      for (int f = 0; f < NF; f++) begin
        if (btn_num_in[f]) m_car[f] = 1;
        if (btn_up_out[f] && f != NF - 1) m_up[f] = 1;
        if (btn_down_out[f] && f != 0) m_down[f] = 1;
      end
    end
  endtask

  task automatic cycle(input logic sv, input logic [NF-1:0] bn, input logic [NF-1:0] bu,
                       input logic [NF-1:0] bd, input logic [2:0] cf, input logic sr);
    service = sv; btn_num_in = bn; btn_up_out = bu; btn_down_out = bd;
    current_floor = cf; serve = sr;
    model_step();
    @(posedge clk); #1;
    check("pending", int'(pending), int'(m_car[NF-1:0] | m_up[NF-1:0] | m_down[NF-1:0]));
    check("dir", int'(dir), m_st);
    check("valid", int'(target_valid), int'(m_vld));
    if (m_vld) check("target", int'(target_floor), m_tgt);
  endtask

  task automatic async_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("arst_pending", int'(pending), 0);
    check("arst_dir", int'(dir), 0);
    check("arst_valid", int'(target_valid), 0);
    check("arst_target", int'(target_floor), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 6; i++) begin
      btn_num_in = (i % 2 == 1) ? '1 : '0;
      @(posedge clk); #1;
      check("r032_pending", int'(pending), 0);
      check("r032_valid", int'(target_valid), 0);
      check("r032_dir", int'(dir), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 6'b010000, 6'b000100, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("r033_dir", int'(dir), 1);
    check("r033_tgt", int'(target_floor), 2);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 2, 0);
    cycle(0, 0, 0, 0, 2, 1);
    cycle(0, 0, 0, 0, 2, 0);
    check("r033_tgt4", int'(target_floor), 4);
    cycle(1, 0, 0, 0, 2, 0);
    cycle(0, 6'b001000, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 6'b000010, 3, 1);
    cycle(0, 0, 0, 0, 3, 0);
    check("r034_dir", int'(dir), 2);
    check("r034_tgt", int'(target_floor), 1);
    cycle(0, 0, 0, 0, 2, 0);
    cycle(0, 0, 0, 0, 1, 1);
    check("r034_pending", int'(pending), 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("r034_dir_idle", int'(dir), 0);
    check("r034_valid", int'(target_valid), 0);
    cycle(0, 0, 0, 0, 2, 0);
    cycle(0, 6'b000100, 0, 0, 2, 1);
    check("r035_pend2", int'(pending[2]), 1);
    cycle(0, 6'b100010, 0, 0, 0, 0);
    cycle(1, '1, '1, '1, 0, 0);
    check("r036_pending", int'(pending), 0);
    check("r036_dir", int'(dir), 0);
    check("r036_valid", int'(target_valid), 0);
    check("r036_tgt", int'(target_floor), 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("r036_no_latch", int'(pending), 0);
    cycle(0, 6'b001000, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 7, 0);
    check("r037_valid", int'(target_valid), 0);
    check("r037_dir", int'(dir), 1);
    cycle(0, 0, 0, 0, 7, 1);
    check("r037_hold", int'(dir), 1);
    check("r037_pending", int'(pending[3]), 1);
    async_reset();
    for (int k = 0; k < 600; k++) begin
      if (k == 300) async_reset();
      cycle($urandom_range(0, 39) == 0,
            NF'($urandom & $urandom & $urandom),
            NF'($urandom & $urandom & $urandom),
            NF'($urandom & $urandom & $urandom),
            ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, NF - 1)),
            $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
